banked_byte_memory: RTL and testbench
=====================================

# banked_byte_memory

Parametrised, byte-addressed data memory for the MEM stage of the pipelined core. It generalises the two-bank even/odd store to `LANES` byte banks and supports byte, half and word loads and stores at any alignment. It adds a request/response handshake, a two-beat sequence for accesses that cross a row boundary, and sign/zero extension of load data. The pipeline holds its EM register while `req_ready` is low.

## Interface
Parameters:
- `ADDR_WIDTH`, default 9: byte-address width. Memory holds 2^ADDR_WIDTH bytes.
- `LANES`, default 4: number of byte banks, one byte each per row. Legal values are 4 and 8.
- `ROWS`, derived: 2^ADDR_WIDTH / LANES. Must be at least 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when both valid and ready are high.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_signed`  in  1  loads only: sign-extend when 1, zero-extend when 0.
- `req_addr`  in  ADDR_WIDTH  byte address of the least-significant byte.
- `req_wdata`  in  32  store data, little-endian; the low bytes are used.
- `resp_valid`  out  1  one-cycle pulse; the access has completed.
- `resp_rdata`  out  32  extended load data. Zero for stores and illegal requests.
- `resp_err`  out  1  high with `resp_valid` for an illegal size.

## Operation
- **Address split:** row = `addr / LANES`, lane = `addr % LANES`.
  - Byte k of an access (k = 0..N-1, N = 1/2/4) maps to the linear byte `addr + k`, taken modulo 2^ADDR_WIDTH.
- **Storage:** banks share one row address per cycle and use per-lane write enables. Memory contents are not reset.
- **Single-beat access:** the access stays in one row when `lane + N <= LANES`.
- **Split access:** the access crosses into the next row when `lane + N > LANES`.
  - Beat 1 covers lanes `lane..LANES-1` of row r.
  - Beat 2 covers lanes `0..(lane+N-LANES-1)` of row `(r+1) mod ROWS`.
  - The wrap from the top row to row 0 is legal. Address 2^ADDR_WIDTH-1 plus 1 is address 0.
- **FSM states:**
  - IDLE: `req_ready`=1.
    - An accepted single-beat or illegal request stays in IDLE.
    - An accepted split request moves to SPLIT and latches the beat-2 row, lanes, data bytes, size, signedness and write flag.
  - SPLIT: `req_ready`=0. Performs beat 2, then returns to IDLE unconditionally.
- **Stores:** bytes are written on the edge that ends their beat. `resp_valid` and `resp_rdata`=0 follow.
- **Loads:** bank reads are synchronous. Bytes are merged into N bytes in little-endian order, then extended to 32 bits:
  - signed: replicate bit 8N-1;
  - unsigned: zero-fill;
  - word: no extension.
- **Illegal size (3):** the request is accepted with no memory access. The response is `resp_err`=1 and `resp_rdata`=0.
- **Requests while not ready:** `req_valid` while `req_ready`=0 is not accepted. The requester holds all request fields stable until accepted.
- **Read-after-write:** a load accepted the cycle after a store to the same bytes returns the new data, because the write completes before the read edge.

## Timing
- **Reset values (asynchronous on `reset`=0):**
  - `req_ready`=0 while reset is asserted;
  - `req_ready`=1 from the first cycle after release;
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0;
  - FSM returns to IDLE.
- **Single-beat or illegal request accepted in cycle T:** `resp_valid` in T+1.
- **Split request accepted in T:**
  - `req_ready`=0 in T+1;
  - `resp_valid` in T+2;
  - the next request can be accepted in T+2.
- **Throughput:** one single-beat access per cycle, back-to-back. A response for request n and the acceptance of request n+1 can occur in the same cycle.
- **Output hold:** `resp_rdata` and `resp_err` hold their last value when `resp_valid`=0. Only the `resp_valid` cycle is meaningful.
- **Reset during SPLIT:**
  - beat-1 bytes already written remain;
  - beat 2 is not performed;
  - no response is issued.

## Test plan
All scenarios use LANES=4 and ADDR_WIDTH=9.
- **Aligned word and byte loads:** store word 0x11223344 @0x010, then load word @0x010.
  - Word load → `resp_valid` 1 cycle after accept, data 0x11223344.
  - Signed byte load @0x013 → 0x00000011.
  - Signed byte load @0x010 → 0x00000044.
- **Row-crossing half-word:** store half 0xBEEF @0x007 → `req_ready` low for 1 cycle, `resp_valid` at T+2.
  - Signed half load @0x007 → 0xFFFFBEEF.
  - Unsigned half load @0x007 → 0x0000BEEF.
  - Unsigned byte load @0x008 → 0x000000BE.
- **Address wrap:** store word 0xCAFEBABE @0x1FE, then load bytes @0x1FE, 0x1FF, 0x000, 0x001 (unsigned) → 0xBE, 0xBA, 0xFE, 0xCA.
  - Word load @0x1FE → 0xCAFEBABE, split timing.
- **Back-to-back throughput:** four aligned word loads on consecutive cycles → `req_ready` stays 1 and `resp_valid` is high for 4 consecutive cycles with the data in order.
- **Illegal size:** `req_size`=3 store of 0xFFFFFFFF @0x020 → `resp_err`=1 and `resp_rdata`=0 at T+1.
  - A subsequent word load @0x020 returns the prior contents.
- **Reset during SPLIT:** accept word store 0xA5A5A5A5 @0x00E, then assert `reset` in T+1.
  - Outputs are 0 immediately and no `resp_valid` is issued.
  - After release, a word load @0x00C shows bytes @0x00E–0x00F = 0xA5 and byte @0x010 unchanged.

Source files
------------

// File: rtl/banked_byte_memory.sv
// Byte-addressed data memory made of LANES byte banks sharing one row address.
// Accesses that run past the end of a row take a second beat in the SPLIT state.
module banked_byte_memory #(
    parameter int ADDR_WIDTH = 9,
    parameter int LANES      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);
    localparam int LW   = $clog2(LANES);
    localparam int RW   = ADDR_WIDTH - LW;
    localparam int ROWS = (2 ** ADDR_WIDTH) / LANES;
    localparam int CW   = LW + 2;

    typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

    function automatic logic [31:0] extend_load(input logic [31:0] data, input logic [1:0] size,
                                                input logic sgn);
        logic [31:0] res;
        case (size)
            2'd0:    res = {{24{sgn & data[7]}}, data[7:0]};
            2'd1:    res = {{16{sgn & data[15]}}, data[15:0]};
            default: res = data;
        endcase
        return res;
    endfunction

    logic [7:0]  mem_q [ROWS][LANES];
    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    // Second-beat context captured when a split access is accepted.
    logic [RW-1:0] b2_row_q, b2_row_d;
    logic [1:0]    b2_cnt_q, b2_cnt_d;
    logic [1:0]    b2_base_q, b2_base_d;
    logic [31:0]   b2_wdata_q, b2_wdata_d;
    logic [1:0]    b2_size_q, b2_size_d;
    logic          b2_signed_q, b2_signed_d;
    logic          b2_write_q, b2_write_d;
    logic [31:0]   part_q, part_d;

    logic [LW-1:0]          lane_s;
    logic [RW-1:0]          row_s;
    logic [CW-1:0]          lane_ext_s;
    logic [CW-1:0]          n_ext_s;
    logic                   accept_s;
    logic                   illegal_s;
    logic                   split_s;
    logic [RW-1:0]          mem_row_s;
    logic [LANES-1:0]       mem_we_s;
    logic [LANES-1:0][7:0]  mem_wbyte_s;
    logic [31:0]            rbyte_s;
    logic [1:0]             off_s;

    // Request decode: row/lane split, access length and row-crossing detection.
    always_comb begin
        lane_s     = req_addr[LW-1:0];
        row_s      = req_addr[ADDR_WIDTH-1:LW];
        lane_ext_s = CW'(lane_s);
        illegal_s  = (req_size == 2'd3);
        case (req_size)
            2'd0:    n_ext_s = CW'(3'd1);
            2'd1:    n_ext_s = CW'(3'd2);
            2'd2:    n_ext_s = CW'(3'd4);
            default: n_ext_s = CW'(3'd0);
        endcase
        split_s  = !illegal_s && ((lane_ext_s + n_ext_s) > CW'(LANES));
        accept_s = req_valid && ready_q;
    end

    // FSM next state, bank enables/data, read merge and response generation.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        b2_row_d     = b2_row_q;
        b2_cnt_d     = b2_cnt_q;
        b2_base_d    = b2_base_q;
        b2_wdata_d   = b2_wdata_q;
        b2_size_d    = b2_size_q;
        b2_signed_d  = b2_signed_q;
        b2_write_d   = b2_write_q;
        part_d       = part_q;
        mem_row_s    = row_s;
        mem_we_s     = '0;
        mem_wbyte_s  = '0;
        rbyte_s      = 32'h0000_0000;
        off_s        = 2'd0;
        case (state_q)
            IDLE: begin
                if (accept_s && !illegal_s) begin
                    // Beat 1 (or the whole access): lanes lane..lane+N-1 clipped to the row.
                    for (int j = 0; j < LANES; j++) begin
                        if ((CW'(j) >= lane_ext_s) && (CW'(j) < (lane_ext_s + n_ext_s))) begin
                            off_s                     = 2'(CW'(j) - lane_ext_s);
                            mem_we_s[j]               = req_write;
                            mem_wbyte_s[j]            = req_wdata[{off_s, 3'b000} +: 8];
                            rbyte_s[{off_s, 3'b000} +: 8] = mem_q[row_s][j];
                        end else begin
                            mem_we_s[j] = 1'b0;
                        end
                    end
                    if (split_s) begin
                        state_d     = SPLIT;
                        b2_row_d    = row_s + RW'(1'b1);
                        b2_cnt_d    = 2'(lane_ext_s + n_ext_s - CW'(LANES));
                        b2_base_d   = 2'(CW'(LANES) - lane_ext_s);
                        b2_wdata_d  = req_wdata;
                        b2_size_d   = req_size;
                        b2_signed_d = req_signed;
                        b2_write_d  = req_write;
                        part_d      = rbyte_s;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_rdata_d = req_write ? 32'h0000_0000
                                                 : extend_load(rbyte_s, req_size, req_signed);
                    end
                end else if (accept_s) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'h0000_0000;
                end else begin
                    state_d = IDLE;
                end
            end
            SPLIT: begin
                mem_row_s = b2_row_q;
                for (int j = 0; j < LANES; j++) begin
                    if (CW'(j) < CW'(b2_cnt_q)) begin
                        off_s                     = 2'(CW'(j) + CW'(b2_base_q));
                        mem_we_s[j]               = b2_write_q;
                        mem_wbyte_s[j]            = b2_wdata_q[{off_s, 3'b000} +: 8];
                        rbyte_s[{off_s, 3'b000} +: 8] = mem_q[b2_row_q][j];
                    end else begin
                        mem_we_s[j] = 1'b0;
                    end
                end
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = b2_write_q ? 32'h0000_0000
                                          : extend_load(part_q | rbyte_s, b2_size_q, b2_signed_q);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // Control and response registers; a reset mid-split abandons beat 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
            b2_row_q     <= '0;
            b2_cnt_q     <= 2'd0;
            b2_base_q    <= 2'd0;
            b2_wdata_q   <= 32'h0000_0000;
            b2_size_q    <= 2'd0;
            b2_signed_q  <= 1'b0;
            b2_write_q   <= 1'b0;
            part_q       <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            b2_row_q     <= b2_row_d;
            b2_cnt_q     <= b2_cnt_d;
            b2_base_q    <= b2_base_d;
            b2_wdata_q   <= b2_wdata_d;
            b2_size_q    <= b2_size_d;
            b2_signed_q  <= b2_signed_d;
            b2_write_q   <= b2_write_d;
            part_q       <= part_d;
        end
    end

    // Byte banks: per-lane write enables on a shared row; contents are not reset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < LANES; j++) begin
            if (mem_we_s[j]) begin
                mem_q[mem_row_s][j] <= mem_wbyte_s[j];
            end
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_banked_byte_memory.sv
// Randomised and directed bench for banked_byte_memory against a flat byte-array model.
module tb_banked_byte_memory;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [8:0]  req_addr = 9'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0]  mm [512];
    int          exp_due [$];
    logic [31:0] exp_data [$];
    logic        exp_err [$];

    banked_byte_memory #(.ADDR_WIDTH(9), .LANES(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Drive one request from a negedge; model predicts the response at acceptance.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [8:0] a,
                         input logic [31:0] wd, input bit partial, output int stalls,
                         output logic [31:0] pred);
        int n;
        int lane;
        bit spl;
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        stalls = 0;
        while (req_ready !== 1'b1 && stalls < 8) begin
            @(negedge clk);
            stalls++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout got %0d exp ready", stalls);
            req_valid = 1'b0;
            pred = 32'd0;
            return;
        end
        n = 1 << sz;
        lane = int'(a) % 4;
        spl = (sz != 2'd3) && (lane + n > 4);
        pred = 32'd0;
        if (sz == 2'd3) begin
            pred = 32'd0;
        end else if (w) begin
            for (int k = 0; k < n; k++)
                if (!partial || lane + k < 4) mm[(int'(a) + k) % 512] = wd[8*k +: 8];
        end else begin
            for (int k = 0; k < n; k++)
                pred = pred | (32'(mm[(int'(a) + k) % 512]) << (8*k));
            if (sg && n < 4 && pred[8*n-1]) pred = pred | (32'hFFFF_FFFF << (8*n));
        end
        if (!partial) begin
            exp_due.push_back(cyc + 1 + (spl ? 1 : 0));
            exp_data.push_back(pred);
            exp_err.push_back(sz == 2'd3);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    // Compare process: every response against the queued model prediction.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (exp_due.size() > 0 && exp_due[0] < cyc) begin
                checks++; errors++;
                $display("FAIL resp_missing got none exp due %0d at %0d", exp_due[0], cyc);
                void'(exp_due.pop_front()); void'(exp_data.pop_front()); void'(exp_err.pop_front());
            end
            if (resp_valid === 1'b1) begin
                checks++;
                if (exp_due.size() == 0 || exp_due[0] != cyc) begin
                    errors++;
                    $display("FAIL resp_unexpected got valid exp none at %0d", cyc);
                end else begin
                    chk("resp_rdata", resp_rdata, exp_data[0]);
                    chk("resp_err", 32'(resp_err), 32'(exp_err[0]));
                    void'(exp_due.pop_front()); void'(exp_data.pop_front()); void'(exp_err.pop_front());
                end
            end
        end
    end

    initial begin
        int st;
        logic [31:0] p;
        logic [31:0] p0;
        #12;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        @(negedge clk); reset = 1'b1; @(negedge clk);
        chk("ready_after_release", 32'(req_ready), 32'd1);

        for (int i = 0; i < 128; i++) issue(1'b1, 2'd2, 1'b0, 9'(i * 4), $urandom, 1'b0, st, p);

        // Aligned word and byte loads
        issue(1'b1, 2'd2, 1'b0, 9'h010, 32'h1122_3344, 1'b0, st, p);
        issue(1'b0, 2'd2, 1'b0, 9'h010, 32'd0, 1'b0, st, p);
        chk("pin_word_010", p, 32'h1122_3344);
        issue(1'b0, 2'd0, 1'b1, 9'h013, 32'd0, 1'b0, st, p);
        chk("pin_sbyte_013", p, 32'h0000_0011);
        issue(1'b0, 2'd0, 1'b1, 9'h010, 32'd0, 1'b0, st, p);
        chk("pin_sbyte_010", p, 32'h0000_0044);

        // Row-crossing half word
        issue(1'b1, 2'd1, 1'b0, 9'h007, 32'h0000_BEEF, 1'b0, st, p);
        issue(1'b0, 2'd1, 1'b1, 9'h007, 32'd0, 1'b0, st, p);
        chk("split_ready_low_cycles", 32'(st), 32'd1);
        chk("pin_shalf_007", p, 32'hFFFF_BEEF);
        issue(1'b0, 2'd1, 1'b0, 9'h007, 32'd0, 1'b0, st, p);
        chk("pin_uhalf_007", p, 32'h0000_BEEF);
        issue(1'b0, 2'd0, 1'b0, 9'h008, 32'd0, 1'b0, st, p);
        chk("pin_ubyte_008", p, 32'h0000_00BE);

        // Address wrap
        issue(1'b1, 2'd2, 1'b0, 9'h1FE, 32'hCAFE_BABE, 1'b0, st, p);
        issue(1'b0, 2'd0, 1'b0, 9'h1FE, 32'd0, 1'b0, st, p);
        chk("pin_wrap_1fe", p, 32'h0000_00BE);
        issue(1'b0, 2'd0, 1'b0, 9'h1FF, 32'd0, 1'b0, st, p);
        chk("pin_wrap_1ff", p, 32'h0000_00BA);
        issue(1'b0, 2'd0, 1'b0, 9'h000, 32'd0, 1'b0, st, p);
        chk("pin_wrap_000", p, 32'h0000_00FE);
        issue(1'b0, 2'd0, 1'b0, 9'h001, 32'd0, 1'b0, st, p);
        chk("pin_wrap_001", p, 32'h0000_00CA);
        issue(1'b0, 2'd2, 1'b0, 9'h1FE, 32'd0, 1'b0, st, p);
        chk("pin_wrap_word", p, 32'hCAFE_BABE);
        idle(); idle();

        // Back-to-back aligned word loads
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 2'd2, 1'b0, 9'(9'h010 + 9'(i * 4)), 32'd0, 1'b0, st, p);
            chk("b2b_no_stall", 32'(st), 32'd0);
        end

        // Illegal size leaves memory untouched
        issue(1'b0, 2'd2, 1'b0, 9'h020, 32'd0, 1'b0, st, p0);
        issue(1'b1, 2'd3, 1'b0, 9'h020, 32'hFFFF_FFFF, 1'b0, st, p);
        issue(1'b0, 2'd2, 1'b0, 9'h020, 32'd0, 1'b0, st, p);
        chk("illegal_no_write_model", p, p0);
        idle(); idle();

        // Reset while the second beat is pending
        issue(1'b1, 2'd2, 1'b0, 9'h00E, 32'hA5A5_A5A5, 1'b1, st, p);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midsplit_rst_ready", 32'(req_ready), 32'd0);
        chk("midsplit_rst_valid", 32'(resp_valid), 32'd0);
        chk("midsplit_rst_rdata", resp_rdata, 32'd0);
        chk("midsplit_rst_err", 32'(resp_err), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(1'b0, 2'd2, 1'b0, 9'h00C, 32'd0, 1'b0, st, p);
        chk("pin_beat1_kept", 32'(p[31:16]), 32'h0000_A5A5);
        issue(1'b0, 2'd0, 1'b0, 9'h010, 32'd0, 1'b0, st, p);
        chk("pin_beat2_dropped", p, 32'h0000_0044);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  9'($urandom_range(0, 511)), $urandom, 1'b0, st, p);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_due.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
